// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads always win the RAM port,
// processor writes wait in a small FIFO and drain into idle (blanking) cycles.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_ready,
    input  logic                          vga_req,
    input  logic [ADDR_W-1:0]             vga_addr,
    output logic [DATA_W-1:0]             vga_rdata,
    output logic                          vga_rvalid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // grant        | meaning
    // IDLE         | nothing to do; RAM address/data hold
    // GRANT_READ   | scan-out read owns the port this cycle
    // GRANT_WRITE  | FIFO head is popped and written to RAM
    typedef enum logic [1:0] {IDLE, GRANT_READ, GRANT_WRITE} grant_e;

    grant_e grant;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [2:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    // Ready comes from the registered level only, so a full FIFO refuses even on a pop cycle.
    assign cpu_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push      = cpu_we && cpu_ready;

    always_comb begin
        grant = IDLE;
        if (vga_req)
            grant = GRANT_READ;
        else if (level_q != '0)
            grant = GRANT_WRITE;
    end

    assign pop = (grant == GRANT_WRITE);

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (grant)
            GRANT_READ: begin
                mem_addr_d = vga_addr;
            end
            GRANT_WRITE: begin
                mem_addr_d  = fifo_addr[rd_ptr_q];
                mem_wdata_d = fifo_data[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
            default: ;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        // Stage 1: address registered, stage 2: RAM data back, stage 3: data captured.
        rvalid_d    = {rvalid_q[1:0], vga_req};
        vga_rdata_d = rvalid_q[1] ? mem_rdata : vga_rdata_q;

        ovf_d = ovf_q | (cpu_we & ~cpu_ready);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rvalid_q    <= '0;
            vga_rdata_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rvalid_q    <= rvalid_d;
            vga_rdata_q <= vga_rdata_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset; the level count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= cpu_addr;
            fifo_data[wr_ptr_q] <= cpu_wdata;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign vga_rvalid = rvalid_q[2];
    assign vga_rdata  = vga_rdata_q;
    assign fifo_level = level_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous-read RAM model whose
// unwritten words read back as the low byte of their address.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [2:0]        fifo_level;
    logic              ovf_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [int];

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .ovf_err    (ovf_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram.exists(int'(mem_addr)))
            mem_rdata <= ram[int'(mem_addr)];
        else
            mem_rdata <= mem_addr[7:0];
        if (mem_we)
            ram[int'(mem_addr)] = mem_wdata;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset     = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;

        // Reset values
        step();
        step();
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check("rst_rvalid",     32'(vga_rvalid), 32'd0);
        check("rst_rdata",      32'(vga_rdata),  32'd0);
        check("rst_level",      32'(fifo_level), 32'd0);
        check("rst_ready",      32'(cpu_ready),  32'd1);
        check("rst_ovf",        32'(ovf_err),    32'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", 32'(cpu_ready),  32'd1);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        // Single write: visible on the RAM port two cycles after acceptance
        cpu_we    = 1'b1;
        cpu_addr  = 19'h00010;
        cpu_wdata = 8'h5A;
        step();
        cpu_we = 1'b0;
        check("sw_level1",  32'(fifo_level), 32'd1);
        check("sw_we_t1",   32'(mem_we),     32'd0);
        step();
        check("sw_we_t2",   32'(mem_we),     32'd1);
        check("sw_addr",    32'(mem_addr),   32'h10);
        check("sw_wdata",   32'(mem_wdata),  32'h5A);
        check("sw_level0",  32'(fifo_level), 32'd0);
        step();
        check("sw_we_t3",   32'(mem_we),     32'd0);

        // Read burst 100..107; valid 3..10 cycles after the first request
        for (int c = 0; c < 12; c++) begin
            vga_req  = (c < 8);
            vga_addr = ADDR_W'(100 + c);
            step();
            check("rb_rvalid", 32'(vga_rvalid), ((c + 1) >= 3 && (c + 1) <= 10) ? 32'd1 : 32'd0);
            if ((c + 1) >= 3 && (c + 1) <= 10)
                check("rb_rdata", 32'(vga_rdata), 32'(100 + c + 1 - 3));
            check("rb_we", 32'(mem_we), 32'd0);
        end
        vga_req = 1'b0;

        // Read back the word written earlier
        vga_req  = 1'b1;
        vga_addr = 19'h00010;
        step();
        vga_req = 1'b0;
        step();
        step();
        check("rd_written_valid", 32'(vga_rvalid), 32'd1);
        check("rd_written_data",  32'(vga_rdata),  32'h5A);
        step();
        step();

        // Priority and fill: reads hold the port, FIFO accepts exactly 4
        n = 0;
        for (int c = 0; c < 20; c++) begin
            vga_req  = 1'b1;
            vga_addr = ADDR_W'(300 + c);
            if (n < 6 && cpu_ready) begin
                cpu_we    = 1'b1;
                cpu_addr  = ADDR_W'(32'h1000 + n);
                cpu_wdata = 8'(8'hA0 + n);
                n++;
            end else begin
                cpu_we = 1'b0;
            end
            step();
            check("fill_we", 32'(mem_we), 32'd0);
        end
        cpu_we = 1'b0;
        check("fill_accepted", 32'(n),          32'd4);
        check("fill_level",    32'(fifo_level), 32'd4);
        check("fill_ready",    32'(cpu_ready),  32'd0);
        check("fill_ovf",      32'(ovf_err),    32'd0);

        // Overflow: one-cycle write while full is dropped and flagged
        cpu_we    = 1'b1;
        cpu_addr  = 19'h02222;
        cpu_wdata = 8'hEE;
        step();
        cpu_we = 1'b0;
        check("ovf_set",   32'(ovf_err),    32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        step();
        step();
        check("ovf_sticky", 32'(ovf_err), 32'd1);
        check("ovf_we",     32'(mem_we),  32'd0);

        // Drain in FIFO order on consecutive cycles once reads stop
        vga_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_we",    32'(mem_we),     32'd1);
            check("drain_addr",  32'(mem_addr),   32'h1000 + 32'(k));
            check("drain_wdata", 32'(mem_wdata),  32'hA0 + 32'(k));
            check("drain_level", 32'(fifo_level), 32'(3 - k));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check("drain_after_we", 32'(mem_we), 32'd0);
        end
        check("drain_ovf_still", 32'(ovf_err),   32'd1);
        check("drain_ready",     32'(cpu_ready), 32'd1);

        // Reset mid-operation: 3 reads in flight, 2 writes queued
        vga_req   = 1'b1;
        vga_addr  = 19'd50;
        cpu_we    = 1'b1;
        cpu_addr  = 19'h03000;
        cpu_wdata = 8'h11;
        step();
        vga_addr  = 19'd51;
        cpu_addr  = 19'h03001;
        cpu_wdata = 8'h22;
        step();
        cpu_we   = 1'b0;
        vga_addr = 19'd52;
        check("mid_level_pre", 32'(fifo_level), 32'd2);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        vga_req = 1'b0;
        check("mid_ovf_clr", 32'(ovf_err),   32'd0);
        check("mid_rdata",   32'(vga_rdata), 32'd0);
        check("mid_addr",    32'(mem_addr),  32'd0);
        for (int k = 0; k < 6; k++) begin
            check("mid_rvalid", 32'(vga_rvalid), 32'd0);
            check("mid_we",     32'(mem_we),     32'd0);
            check("mid_level",  32'(fifo_level), 32'd0);
            check("mid_ready",  32'(cpu_ready),  32'd1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter between the processor's pixel-index write stream and the VGA controller's scan-out read stream. Processor writes are buffered in a small FIFO. VGA reads always win the RAM port. Buffered writes drain into cycles where the VGA controller is not reading, which are mainly the blanking intervals. The block sits between the processor memory-write outputs, the VGA controller, and the frame-buffer RAM, in the VGA clock domain.

## Interface
Parameters:
- ADDR_W, 19, frame-buffer word address width (640x480 = 307200 words).
- DATA_W, 8, pixel index width; the processor write data is truncated to DATA_W LSBs upstream.
- FIFO_DEPTH, 4, write-FIFO entries; must be a power of two, at least 2.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- cpu_we  in  1  write request from the processor.
- cpu_addr  in  ADDR_W  write address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  FIFO can accept; a write is accepted when cpu_we && cpu_ready.
- vga_req  in  1  scan-out read request, one word per cycle.
- vga_addr  in  ADDR_W  read address.
- vga_rdata  out  DATA_W  read data.
- vga_rvalid  out  1  vga_rdata is valid this cycle.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_addr is presented (synchronous read).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
- ovf_err  out  1  sticky flag: cpu_we was seen while cpu_ready=0.

## Operation
- **Write FIFO**
  - Circular buffer with read pointer, write pointer and level count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push on cpu_we && cpu_ready.
  - cpu_ready = (fifo_level != FIFO_DEPTH), computed from the registered level. When full it stays 0 even if a pop happens in the same cycle.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- **Arbitration**, decided each cycle from registered state:
  - GRANT_READ if vga_req=1: mem_addr<=vga_addr, mem_we<=0.
  - Else GRANT_WRITE if fifo_level>0: pop the head entry; mem_addr<=head addr, mem_wdata<=head data, mem_we<=1.
  - Else IDLE: mem_we<=0; mem_addr and mem_wdata hold their values.
- A write pushed in cycle t is eligible for grant no earlier than cycle t+1 (no FIFO bypass).
- Writes are issued in FIFO order, and each accepted write is issued exactly once.
- **Read return pipeline**
  - A 3-stage valid shift register tracks outstanding reads.
  - Stage 3 loads vga_rdata<=mem_rdata.
  - Reads return in order; there is no read/write address-hazard forwarding.
  - A read of an address still held in the FIFO returns the old RAM contents. This is intended: a stale pixel for one frame is acceptable.
- **ovf_err**: set when cpu_we=1 && cpu_ready=0; cleared only by reset. The dropped write is discarded.

## Timing
- Reset (sampled at a clock edge) leaves the following values from the next cycle:
  - mem_we=0, mem_addr=0, mem_wdata=0
  - vga_rvalid=0, vga_rdata=0
  - fifo_level=0, cpu_ready=1, ovf_err=0
  - pointers=0, read valid pipeline cleared
- Reset mid-operation: FIFO contents are lost, in-flight reads are dropped, and no vga_rvalid is produced for requests made before reset.
- Read latency: vga_req=1 in cycle t gives mem_addr in t+1, mem_rdata in t+2, and vga_rvalid=1 with data in t+3. Throughput is one read per cycle.
- Write latency: an accepted write into an empty FIFO with vga_req low appears as mem_we=1 two cycles after acceptance (push, then grant register).
- fifo_level and cpu_ready update one cycle after the push or pop.
- Continuous vga_req stalls writes indefinitely. The FIFO fills and cpu_ready stays 0, so the processor must hold cpu_we until it sees cpu_ready.

## Test plan
- **Reset values**: reset for 2 cycles → all outputs match the Timing reset values; cpu_ready=1 the cycle after reset deasserts.
- **Single write**: write addr=0x00010, data=0x5A with vga_req=0 → mem_we=1, mem_addr=0x00010, mem_wdata=0x5A exactly 2 cycles later; fifo_level returns to 0.
- **Read burst**: preload RAM model with word[a]=a[7:0]; assert vga_req for addrs 100..107 back-to-back → vga_rvalid high for 8 consecutive cycles starting 3 cycles after the first request, data 100..107 in order.
- **Priority and fill**: hold vga_req=1 for 20 cycles while issuing 6 writes →
  - exactly 4 writes are accepted and cpu_ready drops to 0;
  - mem_we stays 0 throughout;
  - after vga_req drops, the 4 writes drain in order on consecutive cycles.
- **Overflow**: with the FIFO full, pulse cpu_we for 1 cycle → ovf_err=1 and stays set; the dropped write never appears on mem_we.
- **Reset mid-operation**: reset while 3 reads are in flight and 2 writes are queued → no vga_rvalid and no mem_we after reset; fifo_level=0.
